// File: rtl/fft_mult_pkg.sv
// Shared definitions for the FFT butterfly multiplier: default widths,
// saturation limits and Wallace-tree sizing helpers.
package fft_mult_pkg;

    localparam int DEF_WIDTH     = 12;
    localparam int DEF_OUT_W     = 12;
    localparam int DEF_FRAC_BITS = 11;
    localparam int DEF_TAG_W     = 4;

    typedef struct packed {
        longint max_v;
        longint min_v;
    } sat_lim_t;

    // Largest and smallest two's complement values representable in out_w bits.
    function automatic sat_lim_t sat_limits(input int out_w);
        sat_lim_t lim;
        lim.max_v = (longint'(1) <<< (out_w - 1)) - 1;
        lim.min_v = -(longint'(1) <<< (out_w - 1));
        return lim;
    endfunction

    // Number of 3:2 compressors that fit on a level holding 'rows' rows.
    function automatic int csa_count(input int rows);
        return rows / 3;
    endfunction

    // Rows left after one level: each compressor turns 3 rows into 2, leftovers pass.
    function automatic int rows_next(input int rows);
        return 2 * csa_count(rows) + (rows % 3);
    endfunction

    // Row count present at a given reduction level (level 0 is the raw matrix).
    function automatic int rows_at(input int rows0, input int level);
        int r;
        r = rows0;
        for (int k = 0; k < level; k++) begin
            r = rows_next(r);
        end
        return r;
    endfunction

    // Levels needed to bring rows0 rows down to a sum/carry pair.
    function automatic int num_levels(input int rows0);
        int r;
        int n;
        r = rows0;
        n = 0;
        while (r > 2) begin
            r = rows_next(r);
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/pipelined_wallace_mult_csa_row.sv
// Row-wide 3:2 carry-save compressor. x + y + z == sum + carry (mod 2^N);
// the carry row is already shifted into its column weight.
module csa_row #(
    parameter int N = 24
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] z,
    output logic [N-1:0] sum,
    output logic [N-1:0] carry
);

    assign sum   = x ^ y ^ z;
    assign carry = ((x & y) | (x & z) | (y & z)) << 1;

endmodule

// File: rtl/pipelined_wallace_mult.sv
// Signed fixed-point multiplier for the FFT butterfly (data x twiddle).
// Baugh-Wooley matrix -> Wallace carry-save tree -> carry-propagate add,
// then arithmetic scaling by FRAC_BITS and saturation to OUT_W bits.
// Three register stages behind a single global stall (valid/ready).
// Build option: define WALLACE_ROUND_NEAREST_EN for round-half-up scaling;
// otherwise the result is truncated (floor).
module pipelined_wallace_mult
    import fft_mult_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int TAG_W     = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] product,
    output logic [TAG_W-1:0] out_tag,
    output logic             ovf
);

    localparam int PW     = 2 * WIDTH;        // full product width
    localparam int M      = WIDTH + 1;        // partial-product rows + constant row
    localparam int LEVELS = num_levels(M);

    if (!(FRAC_BITS < PW && OUT_W <= PW - FRAC_BITS)) begin : g_param_check
        $error("pipelined_wallace_mult: need FRAC_BITS < 2*WIDTH and OUT_W <= 2*WIDTH - FRAC_BITS");
    end

`ifdef WALLACE_ROUND_NEAREST_EN
    localparam logic [63:0] ROUND_ADD = (FRAC_BITS > 0) ? (64'd1 << (FRAC_BITS - 1)) : 64'd0;
`else
    localparam logic [63:0] ROUND_ADD = 64'd0;
`endif

    // Baugh-Wooley correction constants (2^WIDTH + 2^(2*WIDTH-1)) plus the
    // optional rounding addend ride in one extra matrix row, so rounding
    // costs no adder of its own.
    localparam logic [63:0]   BW_CONST  = (64'd1 << WIDTH) + (64'd1 << (PW - 1)) + ROUND_ADD;
    localparam logic [PW-1:0] CONST_ROW = BW_CONST[PW-1:0];

    localparam sat_lim_t             LIM     = sat_limits(OUT_W);
    localparam logic signed [PW-1:0] SAT_MAX = PW'(LIM.max_v);
    localparam logic signed [PW-1:0] SAT_MIN = PW'(LIM.min_v);

    logic             adv;
    logic             s1_valid;
    logic             s2_valid;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [TAG_W-1:0] tag1_q;
    logic [TAG_W-1:0] tag2_q;
    logic [PW-1:0]    sum_q;
    logic [PW-1:0]    carry_q;
    logic [M*PW-1:0]  pp_flat;
    logic [PW-1:0]    red_sum;
    logic [PW-1:0]    red_carry;
    logic signed [PW-1:0] p_shift;
    logic [OUT_W-1:0] prod_d;
    logic             ovf_d;

    // Whole pipeline freezes only when a finished result is being refused.
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    // Valid bits and visible outputs: cleared by reset, shift on advance.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            product   <= '0;
            out_tag   <= '0;
            ovf       <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            product   <= prod_d;
            out_tag   <= tag2_q;
            ovf       <= ovf_d;
        end
    end

    // Datapath registers for S1 operands and the S2 sum/carry pair.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; the stage valid bits decide whether these contents mean anything.
        if (adv) begin
            a_q     <= a;
            b_q     <= b;
            tag1_q  <= in_tag;
            sum_q   <= red_sum;
            carry_q <= red_carry;
            tag2_q  <= tag1_q;
        end
    end

    // Baugh-Wooley matrix: sign-row/sign-column cross terms are inverted,
    // the sign x sign term stays positive; row WIDTH is the constant row.
    always_comb begin
        // NOTE: default the whole vector first so no path leaves a bit unassigned (no latch).
        pp_flat = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if ((i == WIDTH - 1) != (j == WIDTH - 1))
                    pp_flat[i*PW + i + j] = ~(a_q[j] & b_q[i]);
                else
                    pp_flat[i*PW + i + j] = a_q[j] & b_q[i];
            end
        end
        pp_flat[WIDTH*PW +: PW] = CONST_ROW;
    end

    // Wallace tree: each level packs groups of three rows into sum/carry
    // pairs, leftover rows pass straight down, until two rows remain.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int R = rows_at(M, l);
        logic [R*PW-1:0] rows;

        if (l == 0) begin : g_leaf
            assign rows = pp_flat;
        end else begin : g_red
            localparam int RP = rows_at(M, l - 1);
            localparam int G  = csa_count(RP);

            for (genvar g = 0; g < G; g++) begin : g_csa
                csa_row #(.N(PW)) u_csa (
                    .x     (g_lvl[l-1].rows[(3*g)*PW +: PW]),
                    .y     (g_lvl[l-1].rows[(3*g+1)*PW +: PW]),
                    .z     (g_lvl[l-1].rows[(3*g+2)*PW +: PW]),
                    .sum   (rows[(2*g)*PW +: PW]),
                    .carry (rows[(2*g+1)*PW +: PW])
                );
            end

            for (genvar k = 0; k < RP % 3; k++) begin : g_pass
                assign rows[(2*G+k)*PW +: PW] = g_lvl[l-1].rows[(3*G+k)*PW +: PW];
            end
        end
    end

    assign red_sum   = g_lvl[LEVELS].rows[0 +: PW];
    assign red_carry = g_lvl[LEVELS].rows[PW +: PW];

    // S3: carry-propagate add, arithmetic scale, clamp to the OUT_W range.
    always_comb begin
        p_shift = $signed(sum_q + carry_q) >>> FRAC_BITS;
        prod_d  = p_shift[OUT_W-1:0];
        ovf_d   = 1'b0;
        if (p_shift > SAT_MAX) begin
            prod_d = SAT_MAX[OUT_W-1:0];
            ovf_d  = 1'b1;
        end else if (p_shift < SAT_MIN) begin
            prod_d = SAT_MIN[OUT_W-1:0];
            ovf_d  = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipelined_wallace_mult.sv
// Self-checking bench: a 12-bit (Q1.11) and a 16-bit (Q1.15) instance run
// side by side against an arithmetic model of scaled, saturated a*b.
module tb_pipelined_wallace_mult;

    typedef struct {
        longint     p;
        logic       ovf;
        logic [3:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 12-bit instance signals
    logic        in_valid12, in_ready12, out_valid12, out_ready12, ovf12;
    logic [11:0] a12, b12, product12;
    logic [3:0]  tag12, out_tag12;
    // 16-bit instance signals
    logic        in_valid16, in_ready16, out_valid16, out_ready16, ovf16;
    logic [15:0] a16, b16, product16;
    logic [3:0]  tag16, out_tag16;

    int n_checks = 0;
    int n_errors = 0;
    int acc12 = 0, acc16 = 0, rcv12 = 0, rcv16 = 0;
    exp_t q12[$];
    exp_t q16[$];

    pipelined_wallace_mult u12 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid12), .in_ready(in_ready12),
        .a(a12), .b(b12), .in_tag(tag12),
        .out_valid(out_valid12), .out_ready(out_ready12),
        .product(product12), .out_tag(out_tag12), .ovf(ovf12)
    );

    pipelined_wallace_mult #(.WIDTH(16), .OUT_W(16), .FRAC_BITS(15), .TAG_W(4)) u16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .in_tag(tag16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .product(product16), .out_tag(out_tag16), .ovf(ovf16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact product, optional +half-LSB, floor shift, clamp.
    function automatic exp_t model(input longint av, input longint bv, input int ow,
                                   input int f, input logic [3:0] tag);
        exp_t   e;
        longint p, r, mx, mn;
        p = av * bv;
`ifdef WALLACE_ROUND_NEAREST_EN
        if (f > 0) p = p + (longint'(1) << (f - 1));
`endif
        r  = p >>> f;
        mx = (longint'(1) << (ow - 1)) - 1;
        mn = -(longint'(1) << (ow - 1));
        e.ovf = 1'b0;
        if (r > mx) begin
            r = mx;
            e.ovf = 1'b1;
        end else if (r < mn) begin
            r = mn;
            e.ovf = 1'b1;
        end
        e.p   = r & ((longint'(1) << ow) - 1);
        e.tag = tag;
        return e;
    endfunction

    // Random operand with extra weight on the extremes.
    function automatic logic [15:0] pick(input int w);
        int          r;
        logic [15:0] v;
        r = $urandom_range(0, 15);
        v = 16'($urandom);
        case (r)
            0:       v = 16'(1) << (w - 1);
            1:       v = (16'(1) << (w - 1)) - 16'd1;
            2:       v = 16'd0;
            3:       v = 16'hFFFF;
            default: ;
        endcase
        return v;
    endfunction

    // Scoreboard/compare process: every cycle, away from the rising edge.
    logic        stall12 = 1'b0, stall16 = 1'b0;
    logic [11:0] hold_p12;
    logic [15:0] hold_p16;
    logic [3:0]  hold_t12, hold_t16;
    logic        hold_o12, hold_o16;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q12.delete();
            q16.delete();
            stall12 = 1'b0;
            stall16 = 1'b0;
        end else begin
            check("in_ready12", in_ready12, !(out_valid12 && !out_ready12));
            check("in_ready16", in_ready16, !(out_valid16 && !out_ready16));
            if (stall12) begin
                check("hold_valid12", out_valid12, 1);
                check("hold_prod12", product12, hold_p12);
                check("hold_tag12", out_tag12, hold_t12);
                check("hold_ovf12", ovf12, hold_o12);
            end
            if (stall16) begin
                check("hold_valid16", out_valid16, 1);
                check("hold_prod16", product16, hold_p16);
                check("hold_tag16", out_tag16, hold_t16);
                check("hold_ovf16", ovf16, hold_o16);
            end
            if (out_valid12 && out_ready12) begin
                rcv12++;
                check("result_expected12", q12.size() != 0, 1);
                if (q12.size() != 0) begin
                    e = q12.pop_front();
                    check("prod12", product12, e.p);
                    check("ovf12", ovf12, e.ovf);
                    check("tag12", out_tag12, e.tag);
                end
            end
            if (out_valid16 && out_ready16) begin
                rcv16++;
                check("result_expected16", q16.size() != 0, 1);
                if (q16.size() != 0) begin
                    e = q16.pop_front();
                    check("prod16", product16, e.p);
                    check("ovf16", ovf16, e.ovf);
                    check("tag16", out_tag16, e.tag);
                end
            end
            if (in_valid12 && in_ready12) begin
                acc12++;
                q12.push_back(model($signed(a12), $signed(b12), 12, 11, tag12));
            end
            if (in_valid16 && in_ready16) begin
                acc16++;
                q16.push_back(model($signed(a16), $signed(b16), 16, 15, tag16));
            end
            stall12  = out_valid12 && !out_ready12;
            stall16  = out_valid16 && !out_ready16;
            hold_p12 = product12;
            hold_t12 = out_tag12;
            hold_o12 = ovf12;
            hold_p16 = product16;
            hold_t16 = out_tag16;
            hold_o16 = ovf16;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send12(input logic [11:0] av, input logic [11:0] bv, input logic [3:0] t);
        in_valid12 = 1'b1;
        a12 = av;
        b12 = bv;
        tag12 = t;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready12) break;
        end
        check("send12_ready", in_ready12, 1);
        @(posedge clk);
        #1;
        in_valid12 = 1'b0;
    endtask

    task automatic wait_out12(input string name, input logic [11:0] p, input logic o);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid12) break;
        end
        check({name, "_valid"}, out_valid12, 1);
        check({name, "_prod"}, product12, p);
        check({name, "_ovf"}, ovf12, o);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic [15:0] tmp;
        int          sent, r12_start, a12_start, a16_start;
        logic [11:0] exp_rnd_pos, exp_rnd_neg;

`ifdef WALLACE_ROUND_NEAREST_EN
        exp_rnd_pos = 12'h001;
        exp_rnd_neg = 12'h000;
`else
        exp_rnd_pos = 12'h000;
        exp_rnd_neg = 12'hFFF;
`endif

        // Pin the model with hand-computed values.
        e = model(1024, 1024, 12, 11, 0);
        check("model_half_sq", e.p, 12'h200);
        check("model_half_sq_ovf", e.ovf, 0);
        e = model(-2048, -2048, 12, 11, 0);
        check("model_neg1_sq", e.p, 12'h7FF);
        check("model_neg1_sq_ovf", e.ovf, 1);
        e = model(-2048, 2047, 12, 11, 0);
        check("model_neg1_max", e.p, 12'h801);
        check("model_neg1_max_ovf", e.ovf, 0);
        e = model(1, 1024, 12, 11, 0);
        check("model_round_pos", e.p, exp_rnd_pos);
        e = model(-1, 1024, 12, 11, 0);
        check("model_round_neg", e.p, exp_rnd_neg);
        e = model(-32768, -32768, 16, 15, 0);
        check("model16_neg1_sq", e.p, 16'h7FFF);

        // Reset state
        rst = 1'b1;
        in_valid12 = 0; a12 = 0; b12 = 0; tag12 = 0; out_ready12 = 1;
        in_valid16 = 0; a16 = 0; b16 = 0; tag16 = 0; out_ready16 = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid12, 0);
        check("rst_product", product12, 0);
        check("rst_out_tag", out_tag12, 0);
        check("rst_ovf", ovf12, 0);
        check("rst_in_ready", in_ready12, 1);
        check("rst_out_valid16", out_valid16, 0);
        @(posedge clk);
        #1;

        // Latency: result visible in the third cycle after the accepting edge.
        send12(12'h400, 12'h400, 4'h1);
        @(negedge clk);
        check("lat_c1_valid", out_valid12, 0);
        @(negedge clk);
        check("lat_c2_valid", out_valid12, 0);
        @(negedge clk);
        check("lat_c3_valid", out_valid12, 1);
        check("lat_prod", product12, 12'h200);
        check("lat_ovf", ovf12, 0);
        check("lat_tag", out_tag12, 4'h1);
        @(posedge clk);
        #1;

        // Boundary and rounding cases
        send12(12'h800, 12'h800, 4'h2);
        wait_out12("neg1_sq", 12'h7FF, 1'b1);
        send12(12'h800, 12'h7FF, 4'h3);
        wait_out12("neg1_max", 12'h801, 1'b0);
        send12(12'h001, 12'h400, 4'h4);
        wait_out12("round_pos", exp_rnd_pos, 1'b0);
        send12(12'hFFF, 12'h400, 4'h5);
        wait_out12("round_neg", exp_rnd_neg, 1'b0);

        // Stream 8 tagged beats with out_ready 1,0,0,1,0,0,...
        sent = 0;
        r12_start = rcv12;
        for (int cyc = 0; cyc < 200 && (sent < 8 || q12.size() != 0 || out_valid12); cyc++) begin
            out_ready12 = (cyc % 3 == 0);
            in_valid12  = (sent < 8);
            tmp = pick(12);
            a12 = tmp[11:0];
            tmp = pick(12);
            b12 = tmp[11:0];
            tag12 = 4'(sent);
            @(negedge clk);
            if (in_valid12 && in_ready12) sent++;
            @(posedge clk);
            #1;
        end
        in_valid12 = 1'b0;
        out_ready12 = 1'b1;
        check("stream_sent", sent, 8);
        check("stream_received", rcv12 - r12_start, 8);
        check("stream_drained", q12.size(), 0);

        // Reset with three beats in flight, output refused meanwhile.
        out_ready12 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid12 = 1'b1;
            a12 = 12'h123 + 12'(i);
            b12 = 12'h456;
            tag12 = 4'(8 + i);
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        in_valid12 = 1'b0;
        @(negedge clk);
        check("inflight_stalled", out_valid12, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid12, 0);
        check("midrst_in_ready", in_ready12, 1);
        check("midrst_product", product12, 0);
        out_ready12 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("midrst_no_stale", out_valid12, 0);
        end
        @(posedge clk);
        #1;

        // Random traffic on both instances with random back-pressure.
        a12_start = acc12;
        a16_start = acc16;
        for (int cyc = 0; cyc < 45000 && (acc12 - a12_start < 10000 || acc16 - a16_start < 10000); cyc++) begin
            in_valid12 = (acc12 - a12_start < 10000) && ($urandom_range(0, 9) < 8);
            tmp = pick(12);
            a12 = tmp[11:0];
            tmp = pick(12);
            b12 = tmp[11:0];
            tag12 = 4'($urandom);
            out_ready12 = ($urandom_range(0, 3) != 0);
            in_valid16 = (acc16 - a16_start < 10000) && ($urandom_range(0, 9) < 8);
            a16 = pick(16);
            b16 = pick(16);
            tag16 = 4'($urandom);
            out_ready16 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        in_valid12 = 1'b0;
        in_valid16 = 1'b0;
        out_ready12 = 1'b1;
        out_ready16 = 1'b1;
        check("random_count12", acc12 - a12_start, 10000);
        check("random_count16", acc16 - a16_start, 10000);
        for (int k = 0; k < 20 && (q12.size() != 0 || q16.size() != 0); k++) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        check("drain12", q12.size(), 0);
        check("drain16", q16.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
